sign_mag_to_bcd: RTL and testbench

Sequential double-dabble converter that consumes the sign-magnitude word produced by the two's-complement-to-sign-magnitude stage. It emits a sign flag plus packed BCD digits for the display/printing path. One word is accepted through a valid/ready handshake, converted with one shift per clock, and held on a valid/ready output until taken.

---
 rtl/sign_mag_to_bcd.sv | 109 ++++++++++
 tb/tb_sign_mag_to_bcd.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sign_mag_to_bcd.sv
// Sequential double-dabble converter: sign-magnitude word in, sign flag plus packed BCD out.
// One shift per clock; valid/ready on both sides, result held until the consumer takes it.
module sign_mag_to_bcd #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sm_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [4*D-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [4*D-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [4*D-1:0]    adj;

    function automatic logic [4*D-1:0] add3_digits(input logic [4*D-1:0] b);
        logic [4*D-1:0] r;
        r = b;
        for (int i = 0; i < D; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        adj         = add3_digits(bcd_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    sign_d  = sm_in[W-1];
                    // The upstream stage encodes the most negative value as 1 followed by zeros.
                    if (sm_in == MOST_NEG)
                        mag_d = MOST_NEG;
                    else
                        mag_d = {1'b0, sm_in[W-2:0]};
                    bcd_d = '0;
                    cnt_d = CW'(W);
                end
            end
            SHIFT: begin
                bcd_d = (4*D)'({adj, mag_q[W-1]});
                mag_d = {mag_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sign      = sign_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_sign_mag_to_bcd.sv
// Directed bench for sign_mag_to_bcd: an 8-bit/3-digit instance and a 4-bit/1-digit instance.
module tb_sign_mag_to_bcd;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, sign8;
    logic [7:0]  sm8;
    logic [11:0] bcd8;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, sign4;
    logic [3:0]  sm4;
    logic [3:0]  bcd4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sign_mag_to_bcd #(.W(8), .D(3)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .sm_in(sm8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sign(sign8), .bcd(bcd8)
    );

    sign_mag_to_bcd #(.W(4), .D(1)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .sm_in(sm4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sign(sign4), .bcd(bcd4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one word on the 8-bit instance, wait for the result, then complete the handshake.
    task automatic do8(input string tag, input logic [7:0] v, input logic exp_sign, input logic [11:0] exp_bcd);
        int cyc;
        check({tag, "_in_ready"}, in_ready8, 1);
        sm8 = v;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        check({tag, "_sign"}, sign8, exp_sign);
        check({tag, "_bcd"}, bcd8, exp_bcd);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do4(input logic [3:0] v, input logic exp_sign, input logic [3:0] exp_bcd);
        int cyc;
        sm4 = v;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("w4_%0h_latency", v), cyc, 4);
        check($sformatf("w4_%0h_sign", v), sign4, exp_sign);
        check($sformatf("w4_%0h_bcd", v), bcd4, exp_bcd);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1; sm8 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; sm4 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", in_ready8, 1);
        check("rst_out_valid", out_valid8, 0);
        check("rst_sign", sign8, 0);
        check("rst_bcd", bcd8, 12'h000);

        // Single positive word with exact latency.
        sm8 = 8'h05;
        in_valid8 = 1'b1;
        check("p5_ready_before", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("p5_ready_after", in_ready8, 0);
        repeat (7) @(posedge clk);
        #1;
        check("p5_not_yet_valid", out_valid8, 0);
        @(posedge clk); #1;
        check("p5_valid_at_8", out_valid8, 1);
        check("p5_sign", sign8, 0);
        check("p5_bcd", bcd8, 12'h005);
        @(posedge clk); #1;
        check("p5_idle_after_hs", in_ready8, 1);

        do8("max", 8'hFF, 1'b1, 12'h127);
        do8("mostneg", 8'h80, 1'b1, 12'h128);
        do8("zero", 8'h00, 1'b0, 12'h000);
        do8("pos127", 8'h7F, 1'b0, 12'h127);
        do8("neg50", 8'hB2, 1'b1, 12'h050);

        // Backpressure with a busy upstream.
        out_ready8 = 1'b0;
        sm8 = 8'h63;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        sm8 = 8'h11;
        begin
            int cyc;
            cyc = 0;
            while (!out_valid8 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("bp_latency", cyc, 8);
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_valid", i), out_valid8, 1);
            check($sformatf("bp_hold%0d_sign", i), sign8, 0);
            check($sformatf("bp_hold%0d_bcd", i), bcd8, 12'h099);
            check($sformatf("bp_hold%0d_in_ready", i), in_ready8, 0);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_valid", out_valid8, 0);
        check("bp_after_hs_ready", in_ready8, 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("bp_second_accepted", in_ready8, 0);
        begin
            int cyc;
            cyc = 0;
            while (!out_valid8 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("bp2_latency", cyc, 8);
        end
        check("bp2_sign", sign8, 0);
        check("bp2_bcd", bcd8, 12'h017);
        @(posedge clk); #1;

        // Reset during the fourth shift cycle.
        sm8 = 8'h7B;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_partial_bcd", bcd8, 12'h003);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid8, 0);
        check("midrst_bcd", bcd8, 12'h000);
        check("midrst_in_ready", in_ready8, 1);
        check("midrst_sign", sign8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Every output of a 4-bit upstream stage.
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            logic [3:0] eb;
            vv = 4'(v);
            eb = (vv == 4'b1000) ? 4'h8 : {1'b0, vv[2:0]};
            do4(vv, vv[3], eb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
